// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage access unit: memory aluop codes,
// op classification helpers and the access FSM state encoding.
package mips_mem_pkg;

    localparam logic [7:0] ALUOP_LB  = 8'b1110_0000;
    localparam logic [7:0] ALUOP_LBU = 8'b1110_0100;
    localparam logic [7:0] ALUOP_LH  = 8'b1110_0001;
    localparam logic [7:0] ALUOP_LHU = 8'b1110_0101;
    localparam logic [7:0] ALUOP_LW  = 8'b1110_0011;
    localparam logic [7:0] ALUOP_SB  = 8'b1110_1000;
    localparam logic [7:0] ALUOP_SH  = 8'b1110_1001;
    localparam logic [7:0] ALUOP_SW  = 8'b1110_1011;

    typedef enum logic [0:0] {
        MAU_IDLE = 1'b0,
        MAU_BUSY = 1'b1
    } mau_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == ALUOP_LB) || (op == ALUOP_LBU) || (op == ALUOP_LH) ||
               (op == ALUOP_LHU) || (op == ALUOP_LW);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW);
    endfunction

    function automatic logic is_mem(input logic [7:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == ALUOP_LH) || (op == ALUOP_LHU) || (op == ALUOP_SH);
        word_op = (op == ALUOP_LW) || (op == ALUOP_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data bus and register values:
// store byte enables and lane replication, load lane extract and extension.
module mem_lane_align
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 8
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         byte_off,
    input  logic [DATA_W-1:0]  st_data,
    input  logic [DATA_W-1:0]  ld_raw,
    output logic [3:0]         be,
    output logic [DATA_W-1:0]  st_lanes,
    output logic [DATA_W-1:0]  ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: loads read the whole word, sub-word stores replicate data.
    always_comb begin
        be       = 4'b1111;
        st_lanes = '0;
        case (aluop)
            ALUOP_SB: begin
                be       = 4'b0001 << byte_off;
                st_lanes = {4{st_data[7:0]}};
            end
            ALUOP_SH: begin
                be       = byte_off[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            ALUOP_SW: st_lanes = st_data;
            default:  ;
        endcase
    end

    // Load side: pick the addressed lane, shift it to bit 0, then extend.
    always_comb begin
        case (byte_off)
            2'd0:    ld_byte = ld_raw[7:0];
            2'd1:    ld_byte = ld_raw[15:8];
            2'd2:    ld_byte = ld_raw[23:16];
            default: ld_byte = ld_raw[31:24];
        endcase
        ld_half = byte_off[1] ? ld_raw[31:16] : ld_raw[15:0];
        case (aluop)
            ALUOP_LB:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            ALUOP_LBU: ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            ALUOP_LH:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            ALUOP_LHU: ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            default:   ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Non-memory ops pass to MEM/WB in one
// cycle; loads/stores run one req/ack bus transaction while the upstream
// pipeline is stalled; misaligned accesses raise a one-cycle exception.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [REG_AW-1:0]  in_wd,
    input  logic               in_wreg,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic [DATA_W-1:0]  in_mem_addr,
    input  logic [DATA_W-1:0]  in_reg2,
    output logic               stall_req,
    output logic               dm_req,
    output logic               dm_we,
    output logic [DATA_W-1:0]  dm_addr,
    output logic [3:0]         dm_be,
    output logic [DATA_W-1:0]  dm_wdata,
    input  logic               dm_ack,
    input  logic [DATA_W-1:0]  dm_rdata,
    output logic               out_valid,
    output logic [REG_AW-1:0]  out_wd,
    output logic               out_wreg,
    output logic [DATA_W-1:0]  out_wdata,
    output logic               exc_misaligned,
    output logic [DATA_W-1:0]  exc_badvaddr
);

    localparam logic [0:0] IDLE = MAU_IDLE;
    localparam logic [0:0] BUSY = MAU_BUSY;

    logic [0:0]         state;
    logic [ALUOP_W-1:0] aluop_p1;
    logic [1:0]         off_p1;
    logic [REG_AW-1:0]  wd_p1;
    logic               wreg_p1;

    logic               in_mem;
    logic               in_store;
    logic               in_misal;
    logic [ALUOP_W-1:0] sel_aluop;
    logic [1:0]         sel_off;
    logic [3:0]         be_c;
    logic [DATA_W-1:0]  lanes_c;
    logic [DATA_W-1:0]  ldata_c;

    // Classify the incoming EX/MEM entry.
    always_comb begin
        in_mem   = is_mem(in_aluop);
        in_store = is_store(in_aluop);
        in_misal = is_misaligned(in_aluop, in_mem_addr[1:0]);
    end

    // Lane logic follows the live entry in IDLE and the captured op in BUSY.
    always_comb begin
        sel_aluop = (state == BUSY) ? aluop_p1 : in_aluop;
        sel_off   = (state == BUSY) ? off_p1   : in_mem_addr[1:0];
    end

    mem_lane_align #(
        .DATA_W  (DATA_W),
        .ALUOP_W (ALUOP_W)
    ) u_lane (
        .aluop    (sel_aluop),
        .byte_off (sel_off),
        .st_data  (in_reg2),
        .ld_raw   (dm_rdata),
        .be       (be_c),
        .st_lanes (lanes_c),
        .ld_data  (ldata_c)
    );

    // Stall while an aligned memory op is issuing or awaiting its ack.
    always_comb begin
        if (state == BUSY)
            stall_req = !dm_ack;
        else
            stall_req = in_valid && in_mem && !in_misal;
    end

    // Access FSM, bus request registers and MEM/WB result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dm_req         <= 1'b0;
            dm_we          <= 1'b0;
            dm_addr        <= '0;
            dm_be          <= '0;
            dm_wdata       <= '0;
            out_valid      <= 1'b0;
            out_wd         <= '0;
            out_wreg       <= 1'b0;
            out_wdata      <= '0;
            exc_misaligned <= 1'b0;
            exc_badvaddr   <= '0;
            aluop_p1       <= '0;
            off_p1         <= '0;
            wd_p1          <= '0;
            wreg_p1        <= 1'b0;
        end else begin
            exc_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (!in_valid) begin
                        out_valid <= 1'b0;
                        out_wreg  <= 1'b0;
                    end else if (!in_mem) begin
                        out_valid <= 1'b1;
                        out_wd    <= in_wd;
                        out_wreg  <= in_wreg;
                        out_wdata <= in_wdata;
                    end else if (in_misal) begin
                        out_valid      <= 1'b1;
                        out_wd         <= in_wd;
                        out_wreg       <= 1'b0;
                        out_wdata      <= '0;
                        exc_misaligned <= 1'b1;
                        exc_badvaddr   <= in_mem_addr;
                    end else begin
                        out_valid <= 1'b0;
                        out_wreg  <= 1'b0;
                        dm_req    <= 1'b1;
                        dm_we     <= in_store;
                        dm_addr   <= {in_mem_addr[DATA_W-1:2], 2'b00};
                        dm_be     <= be_c;
                        dm_wdata  <= lanes_c;
                        aluop_p1  <= in_aluop;
                        off_p1    <= in_mem_addr[1:0];
                        wd_p1     <= in_wd;
                        wreg_p1   <= in_wreg;
                        state     <= BUSY;
                    end
                end
                default: begin
                    if (dm_ack) begin
                        dm_req    <= 1'b0;
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        out_wd    <= wd_p1;
                        out_wreg  <= is_store(aluop_p1) ? 1'b0 : wreg_p1;
                        out_wdata <= is_store(aluop_p1) ? '0 : ldata_c;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
